tune_sequencer: RTL and testbench

Autonomous melody player upstream of the tone-generator stage. It replaces the raw push-buttons on the tone generator's note-enable vector with a timed sequence from a constant song table. It drives one-hot note enables, so a single note sounds at a time, with a silent gap between notes. Start, stop and loop come from board switches and buttons, which are asynchronous to the clock.

---
 rtl/tune_pkg.sv | 39 +++
 rtl/tune_sequencer_if.sv | 17 +
 rtl/tune_sequencer_tick_gen.sv | 25 ++
 rtl/tune_sequencer.sv | 133 +++++++++++++
 tb/tb_tune_sequencer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tune_pkg.sv
// Shared types and the default song table for the tune sequencer.
// A table entry is a rest flag, a note index and a duration in ticks.
package tune_pkg;

   localparam int NOTE_LINES   = 4;
   localparam int IDX_W        = $clog2(NOTE_LINES);
   localparam int DUR_W        = 8;
   localparam int SONG_LEN_DEF = 8;

   typedef struct packed {
      logic             rest;
      logic [IDX_W-1:0] idx;
      logic [DUR_W-1:0] dur;
   } note_t;

   typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

   // Durations that do not fit the 8-bit field saturate at 255 ticks.
   function automatic note_t mk_note(input logic rest, input int idx, input int dur);
      note_t n;
      n.rest = rest;
      n.idx  = IDX_W'(idx);
      n.dur  = (dur > (1 << DUR_W) - 1) ? {DUR_W{1'b1}} : DUR_W'(dur);
      return n;
   endfunction

   // A zero duration still plays for one tick.
   function automatic logic [DUR_W-1:0] eff_dur(input note_t n);
      return (n.dur == '0) ? DUR_W'(1) : n.dur;
   endfunction

   // Entry 0 is the rightmost element: C D E F rest F E D.
   localparam note_t [SONG_LEN_DEF-1:0] SONG = {
      mk_note(1'b0, 1, 400), mk_note(1'b0, 2, 200), mk_note(1'b0, 3, 200),
      mk_note(1'b1, 0, 100), mk_note(1'b0, 3, 400), mk_note(1'b0, 2, 200),
      mk_note(1'b0, 1, 200), mk_note(1'b0, 0, 200)
   };

endpackage

// File: rtl/tune_sequencer_if.sv
// Control and status bundle between board switches/buttons and the sequencer.
// The master side drives start/stop/loop; the sequencer is the slave.
interface tune_sequencer_if #(
   parameter int N      = 4,
   parameter int STEP_W = 3
);
   logic              start;
   logic              stop;
   logic              loop;
   logic [N-1:0]      note_en;
   logic              busy;
   logic [STEP_W-1:0] step;
   logic              done;

   modport master (output start, stop, loop, input note_en, busy, step, done);
   modport slave  (input start, stop, loop, output note_en, busy, step, done);
endinterface

// File: rtl/tune_sequencer_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every DIV clocks.
// clr restarts the period so a new state always sees a full first tick.
module tick_gen #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_reg <= '0;
      else if (clr || tick)
         cnt_reg <= '0;
      else
         cnt_reg <= cnt_reg + 1'b1;
   end

   assign tick = (cnt_reg == CW'(DIV - 1));
endmodule

// File: rtl/tune_sequencer.sv
// Plays a constant song table as one-hot note enables with a silent gap
// after every entry; start/stop/loop arrive asynchronously from the board.
module tune_sequencer import tune_pkg::*; #(
   parameter int N         = NOTE_LINES,
   parameter int CLK_HZ    = 100_000_000,
   parameter int TICK_HZ   = 1000,
   parameter int SONG_LEN  = SONG_LEN_DEF,
   parameter int GAP_TICKS = 20,
   parameter note_t [SONG_LEN-1:0] SONG_TABLE = SONG
) (
   input logic              CLK100MHZ,
   input logic              CPU_RESETN,
   tune_sequencer_if.slave  bus
);
   localparam int TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int STEP_W   = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SONG_LEN - 1);
   localparam logic [DUR_W-1:0]  GAP_LOAD  = DUR_W'(GAP_TICKS);

   logic [2:0]        start_sync_reg, stop_sync_reg;
   logic [1:0]        loop_sync_reg;
   state_t            state_reg, state_next;
   logic [STEP_W-1:0] step_reg, step_next;
   logic [DUR_W-1:0]  cnt_reg, cnt_next;
   logic [N-1:0]      note_en_reg, note_en_next;
   logic              busy_reg, busy_next;
   logic              done_reg, done_next;
   logic              start_edge, stop_edge, loop_lvl;
   logic              tick, enter, gap_exit;

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         start_sync_reg <= '0;
         stop_sync_reg  <= '0;
         loop_sync_reg  <= '0;
      end else begin
         start_sync_reg <= {start_sync_reg[1:0], bus.start};
         stop_sync_reg  <= {stop_sync_reg[1:0], bus.stop};
         loop_sync_reg  <= {loop_sync_reg[0], bus.loop};
      end
   end

   assign start_edge = start_sync_reg[1] & ~start_sync_reg[2];
   assign stop_edge  = stop_sync_reg[1] & ~stop_sync_reg[2];
   assign loop_lvl   = loop_sync_reg[1];

   tick_gen #(.DIV(TICK_DIV)) u_tick (
      .clk   (CLK100MHZ),
      .rst_n (CPU_RESETN),
      .clr   (enter),
      .tick  (tick)
   );

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state_reg   <= IDLE;
         step_reg    <= '0;
         cnt_reg     <= '0;
         note_en_reg <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         step_reg    <= step_next;
         cnt_reg     <= cnt_next;
         note_en_reg <= note_en_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      step_next    = step_reg;
      cnt_next     = cnt_reg;
      done_next    = 1'b0;
      enter        = 1'b0;
      gap_exit     = 1'b0;
      note_en_next = '0;
      if (stop_edge) begin
         state_next = IDLE;
         step_next  = '0;
         enter      = (state_reg != IDLE);
      end else begin
         case (state_reg)
            IDLE: if (start_edge) begin
               state_next = NOTE;
               step_next  = '0;
               cnt_next   = eff_dur(SONG_TABLE[0]);
               enter      = 1'b1;
            end
            NOTE: if (tick) begin
               if (cnt_reg != DUR_W'(1))
                  cnt_next = cnt_reg - 1'b1;
               else if (GAP_TICKS != 0) begin
                  state_next = GAP;
                  cnt_next   = GAP_LOAD;
                  enter      = 1'b1;
               end else
                  gap_exit = 1'b1;
            end
            GAP: if (tick) begin
               if (cnt_reg != DUR_W'(1))
                  cnt_next = cnt_reg - 1'b1;
               else
                  gap_exit = 1'b1;
            end
            default: state_next = IDLE;
         endcase
         if (gap_exit) begin
            enter = 1'b1;
            if (step_reg != LAST_STEP || loop_lvl) begin
               state_next = NOTE;
               step_next  = (step_reg != LAST_STEP) ? step_reg + 1'b1 : '0;
               cnt_next   = eff_dur(SONG_TABLE[step_next]);
            end else begin
               state_next = IDLE;
               step_next  = '0;
               done_next  = 1'b1;
            end
         end
      end
      // Outputs are registered from the next state so note_en is glitch-free.
      if (state_next == NOTE && !SONG_TABLE[step_next].rest)
         note_en_next = N'(1) << SONG_TABLE[step_next].idx;
      busy_next = (state_next != IDLE);
   end

   assign bus.note_en = note_en_reg;
   assign bus.busy    = busy_reg;
   assign bus.step    = step_reg;
   assign bus.done    = done_reg;
endmodule

// File: tb/tb_tune_sequencer.sv
// Scoreboard bench: each scenario queues the expected per-cycle outputs,
// then pops and compares them against the sequencer on falling clock edges.
module tb_tune_sequencer;
   import tune_pkg::*;

   localparam int N  = 4;
   localparam int SL = 3;
   localparam int SW = 2;
   localparam note_t [SL-1:0] TEST_SONG = {
      mk_note(1'b0, 3, 1), mk_note(1'b1, 0, 1), mk_note(1'b0, 0, 2)
   };

   typedef struct packed {
      logic [N-1:0]  note_en;
      logic          busy;
      logic          done;
      logic [SW-1:0] step;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n;
   obs_t exp_q[$];
   int   compared   = 0;
   int   mismatched = 0;

   always #5 clk = ~clk;

   tune_sequencer_if #(.N(N), .STEP_W(SW)) bus();

   tune_sequencer #(
      .N(N), .CLK_HZ(1000), .TICK_HZ(100), .SONG_LEN(SL), .GAP_TICKS(2),
      .SONG_TABLE(TEST_SONG)
   ) dut (
      .CLK100MHZ  (clk),
      .CPU_RESETN (rst_n),
      .bus        (bus.slave)
   );

   function automatic obs_t mk_obs(input logic [N-1:0] ne, input logic b,
                                   input logic d, input logic [SW-1:0] s);
      obs_t o;
      o.note_en = ne; o.busy = b; o.done = d; o.step = s;
      return o;
   endfunction

   function automatic obs_t observe();
      return mk_obs(bus.note_en, bus.busy, bus.done, bus.step);
   endfunction

   // Expected trace for one start pulse issued on a falling edge.
   task automatic push_song(input bit loop_mode);
      repeat (2)  exp_q.push_back(mk_obs(4'b0000, 1'b0, 1'b0, 2'd0));
      repeat (20) exp_q.push_back(mk_obs(4'b0001, 1'b1, 1'b0, 2'd0));
      repeat (20) exp_q.push_back(mk_obs(4'b0000, 1'b1, 1'b0, 2'd0));
      repeat (30) exp_q.push_back(mk_obs(4'b0000, 1'b1, 1'b0, 2'd1));
      repeat (10) exp_q.push_back(mk_obs(4'b1000, 1'b1, 1'b0, 2'd2));
      repeat (20) exp_q.push_back(mk_obs(4'b0000, 1'b1, 1'b0, 2'd2));
      if (loop_mode)
         repeat (3) exp_q.push_back(mk_obs(4'b0001, 1'b1, 1'b0, 2'd0));
      else begin
         exp_q.push_back(mk_obs(4'b0000, 1'b0, 1'b1, 2'd0));
         exp_q.push_back(mk_obs(4'b0000, 1'b0, 1'b0, 2'd0));
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         compared++;
         if (!$onehot0(bus.note_en) || (!bus.busy && bus.note_en != '0)) begin
            mismatched++;
            $display("FAIL invariant: got note_en=%b busy=%b, want onehot0 and silent when idle",
                     bus.note_en, bus.busy);
         end
      end
   end

   task automatic test_reset();
      obs_t e;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         compared++;
         if (observe() !== mk_obs('0, 1'b0, 1'b0, '0)) begin
            mismatched++;
            $display("FAIL reset_hold[%0d]: got %b want %b", i, observe(), mk_obs('0, 1'b0, 1'b0, '0));
         end
         bus.start = 1'($urandom); bus.stop = 1'($urandom); bus.loop = 1'($urandom);
      end
      bus.start = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) exp_q.push_back(mk_obs('0, 1'b0, 1'b0, '0));
      for (int i = 0; exp_q.size() > 0; i++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         compared++;
         if (observe() !== e) begin
            mismatched++;
            $display("FAIL reset_release[%0d]: got %b want %b", i, observe(), e);
         end
      end
      $display("test_reset: done");
   endtask

   task automatic test_single_play();
      obs_t e;
      bus.start = 1'b1;
      push_song(1'b0);
      for (int i = 0; exp_q.size() > 0; i++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         compared++;
         if (observe() !== e) begin
            mismatched++;
            $display("FAIL single_play[%0d]: got %b want %b", i, observe(), e);
         end
         if (i == 0) bus.start = 1'b0;
      end
      $display("test_single_play: done");
   endtask

   task automatic test_loop();
      obs_t e;
      bus.loop  = 1'b1;
      bus.start = 1'b1;
      push_song(1'b1);
      for (int i = 0; exp_q.size() > 0; i++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         compared++;
         if (observe() !== e) begin
            mismatched++;
            $display("FAIL loop_play[%0d]: got %b want %b", i, observe(), e);
         end
         if (i == 0) bus.start = 1'b0;
      end
      bus.stop = 1'b1;
      repeat (3) @(negedge clk);
      compared++;
      if (observe() !== mk_obs('0, 1'b0, 1'b0, '0)) begin
         mismatched++;
         $display("FAIL loop_stop: got %b want %b", observe(), mk_obs('0, 1'b0, 1'b0, '0));
      end
      bus.stop = 1'b0;
      bus.loop = 1'b0;
      $display("test_loop: done");
   endtask

   task automatic test_stop();
      obs_t e;
      bus.start = 1'b1;
      repeat (2) exp_q.push_back(mk_obs('0, 1'b0, 1'b0, '0));
      repeat (7) exp_q.push_back(mk_obs(4'b0001, 1'b1, 1'b0, '0));
      repeat (3) exp_q.push_back(mk_obs('0, 1'b0, 1'b0, '0));
      for (int i = 0; exp_q.size() > 0; i++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         compared++;
         if (observe() !== e) begin
            mismatched++;
            $display("FAIL stop_mid_note[%0d]: got %b want %b", i, observe(), e);
         end
         if (i == 0) bus.start = 1'b0;
         if (i == 6) bus.stop = 1'b1;
         if (i == 7) bus.stop = 1'b0;
      end
      $display("test_stop: done");
   endtask

   task automatic test_start_stop_same_cycle();
      obs_t e;
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      repeat (8) exp_q.push_back(mk_obs('0, 1'b0, 1'b0, '0));
      for (int i = 0; exp_q.size() > 0; i++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         compared++;
         if (observe() !== e) begin
            mismatched++;
            $display("FAIL start_stop_same[%0d]: got %b want %b", i, observe(), e);
         end
         if (i == 0) begin bus.start = 1'b0; bus.stop = 1'b0; end
      end
      $display("test_start_stop_same_cycle: done");
   endtask

   task automatic test_restart_ignored();
      obs_t e;
      bus.start = 1'b1;
      push_song(1'b0);
      for (int i = 0; exp_q.size() > 0; i++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         compared++;
         if (observe() !== e) begin
            mismatched++;
            $display("FAIL restart_ignored[%0d]: got %b want %b", i, observe(), e);
         end
         if (i == 0 || i == 76) bus.start = 1'b0;
         if (i == 75) bus.start = 1'b1;
      end
      $display("test_restart_ignored: done");
   endtask

   task automatic test_reset_mid_note();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      compared++;
      if (bus.note_en !== 4'b0001) begin
         mismatched++;
         $display("FAIL pre_reset_note: got %b want %b", bus.note_en, 4'b0001);
      end
      #2 rst_n = 1'b0;
      #1;
      compared++;
      if (bus.note_en !== 4'b0000 || bus.busy !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_mid_note: got note_en=%b busy=%b want 0000 0", bus.note_en, bus.busy);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      $display("test_reset_mid_note: done");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got still running want finished");
      $fatal(1);
   end

   initial begin
      bus.start = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      test_reset();
      repeat (4) @(negedge clk);
      test_single_play();
      repeat (4) @(negedge clk);
      test_loop();
      repeat (4) @(negedge clk);
      test_stop();
      repeat (4) @(negedge clk);
      test_start_stop_same_cycle();
      repeat (4) @(negedge clk);
      test_restart_ignored();
      repeat (4) @(negedge clk);
      test_reset_mid_note();
      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
